ssp_itest_ctrl: RTL

Parametrised integration-test and test-mode controller for the SSP peripheral. It holds the test control register (TCR), the integration-test input (ITIP) and output (ITOP) registers, and a sticky capture register (ITCAP). It muxes NUM_IN functional inputs and NUM_OUT functional outputs between live logic and register values, and implements loopback plus the test-FIFO read-pointer increment. It adds two features: auto-clearing pulse mode for ITOP, and sticky capture of functional outputs for readback. It sits between the APB register decode and the SSP core and pad ring.

---
 rtl/ssp_itest_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ssp_itest_ctrl.sv
// ssp_itest_ctrl: integration-test and test-mode controller for the SSP.
// Holds TCR/ITIP/ITOP/ITCAP, muxes functional inputs/outputs against the
// test registers, provides loopback and the test-FIFO read increment.
// Optional feature macro: SSP_ITEST_PULSE_EN (auto-clearing ITOP pulse mode).
// Handshake note: all strobes (TCRWr/ITIPWr/ITOPWr) are single-cycle
// qualifiers sampled on the PCLK rising edge; there is no back-pressure.
module ssp_itest_ctrl #(
   parameter int NUM_OUT      = 14,
   parameter int NUM_IN       = 2,
   parameter int DW           = 16,
   parameter int PULSE_CYCLES = 4
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [DW-1:0]      PWDATAIn,
   input  logic               TCRWr,
   input  logic               ITIPWr,
   input  logic               ITOPWr,
   input  logic               TDRRd,
   input  logic               LBM,
   input  logic               SSPRXD,
   input  logic               TXD,
   input  logic [NUM_IN-1:0]  FuncIn,
   input  logic [NUM_OUT-1:0] FuncOut,
   output logic               IntSSPRXD,
   output logic [NUM_IN-1:0]  IntIn,
   output logic [NUM_OUT-1:0] IntOut,
   output logic [3:0]         SSPTCR,
   output logic [NUM_OUT-1:0] SSPITOP,
   output logic [NUM_OUT-1:0] SSPITCAP,
   output logic               ITEN,
   output logic               TESTFIFO,
   output logic               PulseBusy,
   output logic               TestTXFInc
);

`ifdef SSP_ITEST_PULSE_EN
   localparam logic [3:0] TCR_MASK = 4'b1111;
`else
   // Without pulse support the PULSE bit is never stored and reads 0.
   localparam logic [3:0] TCR_MASK = 4'b1011;
`endif

   logic [3:0]         tcr;
   logic [3:0]         tcr_next;
   logic [NUM_IN-1:0]  itip;
   logic [NUM_OUT-1:0] itop;
   logic [NUM_OUT-1:0] itcap;
   logic               del_tdrrd;
   logic               unused_wdata;

   // TCR value as it will be after this edge; pulse start/abort decisions
   // look at it so a simultaneous TCR write takes priority over pulse mode.
   assign tcr_next     = TCRWr ? (PWDATAIn[3:0] & TCR_MASK) : tcr;
   assign unused_wdata = ^PWDATAIn;

   // Test control register and integration-test input register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tcr  <= '0;
         itip <= '0;
      end else begin
         tcr <= tcr_next;
         if (ITIPWr) itip <= PWDATAIn[NUM_IN-1:0];
      end
   end

   // Sticky capture: cleared when CAPEN rises, else OR-accumulate while enabled
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         itcap <= '0;
      end else if (TCRWr && PWDATAIn[3] && !tcr[3]) begin
         itcap <= '0;
      end else if (tcr[3]) begin
         itcap <= itcap | FuncOut;
      end
   end

   // Delayed TDR read, only tracked while the test FIFO mode is on
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         del_tdrrd <= 1'b0;
      end else if (tcr[1]) begin
         del_tdrrd <= TDRRd;
      end
   end

`ifdef SSP_ITEST_PULSE_EN
   typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} state_t;
   localparam logic [7:0] CNT_LOAD = 8'(PULSE_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       pulse_mode;
   logic       pulse_busy;

   assign pulse_mode = tcr_next[0] & tcr_next[2];

   // Pulse FSM: owns ITOP, loads/reloads the counter, clears ITOP on expiry or abort
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state      <= IDLE;
         cnt        <= '0;
         itop       <= '0;
         pulse_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ITOPWr) begin
                  itop <= PWDATAIn[NUM_OUT-1:0];
                  if (pulse_mode) begin
                     state      <= PULSE;
                     cnt        <= CNT_LOAD;
                     pulse_busy <= 1'b1;
                  end
               end
            end
            PULSE: begin
               if (ITOPWr) begin
                  // Restart; a write that coincides with leaving pulse mode is static
                  itop <= PWDATAIn[NUM_OUT-1:0];
                  cnt  <= CNT_LOAD;
                  if (!pulse_mode) begin
                     state      <= IDLE;
                     pulse_busy <= 1'b0;
                  end
               end else if (!pulse_mode || cnt == 8'd0) begin
                  itop       <= '0;
                  state      <= IDLE;
                  pulse_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
         endcase
      end
   end

   assign PulseBusy = pulse_busy;
`else
   // Static ITOP register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         itop <= '0;
      end else if (ITOPWr) begin
         itop <= PWDATAIn[NUM_OUT-1:0];
      end
   end

   assign PulseBusy = 1'b0;
`endif

   assign IntSSPRXD  = LBM ? TXD : SSPRXD;
   assign IntIn      = tcr[0] ? itip : FuncIn;
   assign IntOut     = tcr[0] ? itop : FuncOut;
   assign SSPTCR     = tcr;
   assign SSPITOP    = itop;
   assign SSPITCAP   = itcap;
   assign ITEN       = tcr[0];
   assign TESTFIFO   = tcr[1];
   assign TestTXFInc = TDRRd & del_tdrrd;

endmodule
